// File: rtl/aes128_decrypt_seq.sv
`default_nettype none
// ============================================================================
// aes128_decrypt_seq - iterative AES-128 decryption, one inverse round per cycle,
// forward key expansion into a cached 11-entry round-key bank. Revision 1.0
// ============================================================================
module aes128_decrypt_seq #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXPAND = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Byte i lives at bits [127-8i -: 8]; column c holds bytes 4c..4c+3, row = i%4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
            o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
            o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
            o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       state_q;
    logic [127:0] rk_q [0:10];
    logic [127:0] s_q;
    logic [127:0] ct_q;
    logic [3:0]   rnd_q;
    logic         key_valid_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [127:0] rk_sel;
    logic [127:0] rk_prev;
    logic [127:0] isb;
    logic [127:0] rk_exp_d;
    logic [127:0] s_init_d;
    logic [127:0] s_round_d;
    logic [127:0] s_final_d;
    logic         key_hit;

    // Explicit muxes keep every bank access inside 0..10 whatever rnd holds.
    always_comb begin
        rk_sel  = '0;
        rk_prev = '0;
        for (int i = 0; i < 11; i++) begin
            if (rnd_q == 4'(i))     rk_sel  = rk_q[i];
            if (rnd_q == 4'(i + 1)) rk_prev = rk_q[i];
        end
    end

    assign isb       = inv_sub_bytes(inv_shift_rows(s_q));
    assign rk_exp_d  = key_expansion(rk_prev, rcon(rnd_q));
    assign s_init_d  = ct_q ^ rk_q[10];
    assign s_round_d = inv_mix_columns(isb ^ rk_sel);
    assign s_final_d = isb ^ rk_q[0];
    assign key_hit   = (KEY_CACHE != 0) && key_valid_q && (in_key == rk_q[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
            s_q         <= '0;
            ct_q        <= '0;
            rnd_q       <= '0;
            key_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        ct_q       <= in_data;
                        rk_q[0]    <= in_key;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (key_hit) begin
                            state_q <= ST_INIT;
                        end else begin
                            rnd_q       <= 4'd1;
                            key_valid_q <= 1'b0;
                            state_q     <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    for (int i = 1; i < 11; i++) begin
                        if (rnd_q == 4'(i)) rk_q[i] <= rk_exp_d;
                    end
                    if (rnd_q >= 4'd10) begin
                        key_valid_q <= 1'b1;
                        state_q     <= ST_INIT;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ST_INIT: begin
                    s_q     <= s_init_d;
                    rnd_q   <= 4'd9;
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    s_q <= s_round_d;
                    if (rnd_q <= 4'd1) begin
                        rnd_q   <= 4'd0;
                        state_q <= ST_FINAL;
                    end else begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                ST_FINAL: begin
                    s_q         <= s_final_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rnd_q       <= 4'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = s_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_decrypt_seq.sv
`default_nettype none
// ============================================================================
// tb_aes128_decrypt_seq - scoreboard bench for the iterative AES-128 decryptor
// using FIPS-197 vectors. Revision 1.0
// ============================================================================
module tb_aes128_decrypt_seq;

    localparam logic [127:0] C_K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, in_key, out_data;
    logic         nc_in_valid, nc_in_ready, nc_out_valid, nc_out_ready, nc_busy;
    logic [127:0] nc_in_data, nc_in_key, nc_out_data;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           pass_cnt = 0;
    int           total_cnt = 0;
    int           cyc = 0;
    int           n_out = 0;
    int           n_push = 0;
    logic [127:0] held;

    aes128_decrypt_seq #(.KEY_CACHE(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes128_decrypt_seq #(.KEY_CACHE(0)) u_nc (
        .clk(clk), .rst(rst),
        .in_valid(nc_in_valid), .in_ready(nc_in_ready), .in_data(nc_in_data), .in_key(nc_in_key),
        .out_valid(nc_out_valid), .out_ready(nc_out_ready), .out_data(nc_out_data), .busy(nc_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                        input int lat, input bit push, input bit keep, output int acc);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_key   = key;
        in_data  = ct;
        k = 0;
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", in_ready, 1'b1);
        acc = -1;
        if (in_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (push) begin
                sb.push_back('{pt: pt, lat: lat, acc: acc});
                n_push++;
            end
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int  k;
        logic ok;
        k  = 0;
        ok = 1'b0;
        while (k < 400 && !ok) begin
            @(negedge clk);
            ok = in_ready && (sb.size() == 0);
            k++;
        end
        check("idle_reached", ok, 1'b1);
    endtask

    task automatic nc_run();
        int acc, lat, k;
        @(negedge clk);
        nc_in_valid = 1'b1;
        nc_in_key   = C_K1;
        nc_in_data  = C_C1;
        k = 0;
        while (!nc_in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        nc_in_valid = 1'b0;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (nc_out_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        check("nc_latency", lat, 21);
        check("nc_pt", nc_out_data, C_P1);
    endtask

    // Scoreboard monitor: pops on the first cycle of each output, then checks hold.
    initial begin
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_output: got %h with no block outstanding", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("plaintext", out_data, e.pt);
                        check("latency", cyc - e.acc, e.lat);
                    end
                    held = out_data;
                end else if (out_valid) begin
                    check("out_hold", out_data, held);
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        int   acc;
        int   accs[4];
        int   k;
        logic flag;

        rst = 1'b1;
        in_valid = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b1;
        nc_in_valid = 1'b0; nc_in_key = '0; nc_in_data = '0; nc_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, '0);
        rst = 1'b0;

        // Uncached variant: a repeated key still re-expands
        nc_run();
        nc_run();

        // Cold miss with busy held throughout
        send(C_K1, C_C1, C_P1, 21, 1'b1, 1'b0, acc);
        flag = 1'b1;
        for (int j = 0; j < 21; j++) begin
            @(negedge clk);
            flag = flag & busy & ~in_ready;
        end
        check("busy_throughout", flag, 1'b1);
        wait_idle();

        send(C_K1, C_C1, C_P1, 11, 1'b1, 1'b0, acc);
        wait_idle();

        send(C_K2, C_C2, C_P2, 21, 1'b1, 1'b0, acc);
        wait_idle();
        check("rk10", u_dut.rk_q[10], C_RK10);

        // Backpressure with ignored input pulses
        out_ready = 1'b0;
        send(C_K2, C_C2, C_P2, 11, 1'b1, 1'b0, acc);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("bp_out_valid", out_valid, 1'b1);
        flag = 1'b1;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            flag     = flag & ~in_ready & busy & out_valid;
            in_valid = j[0];
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_blocked", flag, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);
        repeat (5) @(negedge clk);
        check("bp_no_extra_accept", busy, 1'b0);

        // Asynchronous reset in the middle of ROUND
        send(C_K1, C_C1, C_P1, 21, 1'b0, 1'b0, acc);
        repeat (15) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_out_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        send(C_K1, C_C1, C_P1, 21, 1'b1, 1'b0, acc);
        wait_idle();

        // Back-to-back cached blocks
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            send(C_K1, C_C1, C_P1, 11, 1'b1, (b != 3), accs[b]);
        end
        for (int b = 1; b < 4; b++) begin
            check("b2b_interval", accs[b] - accs[b-1], 13);
        end
        wait_idle();

        check("out_count", n_out, n_push);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
